// File: rtl/zl_rs_pkg.sv
// Shared Reed-Solomon helpers: width function, encoder state encoding and
// generator-coefficient unpacking for the zl_rs encoder/decoder family.
package zl_rs_pkg;

   typedef enum logic {
      ST_DATA   = 1'b0,
      ST_PARITY = 1'b1
   } rs_state_t;

   localparam int GX_MAX_BITS = 4096;

   // Width needed to hold 0..value-1, never below one bit.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << w) < value) w = w + 1;
      end
      return w;
   endfunction

   function automatic logic [15:0] gx_coef(input logic [GX_MAX_BITS-1:0] gx,
                                           input int m,
                                           input int idx);
      logic [GX_MAX_BITS-1:0] sh;
      logic [31:0]            mask;
      sh   = gx >> (m * idx);
      mask = (32'h1 << m) - 32'h1;
      return 16'(sh[31:0] & mask);
   endfunction

endpackage

// File: rtl/zl_gf_mul.sv
// Combinational GF(2^M) multiplier, shift-and-add reduced by field polynomial POLY.
module zl_gf_mul #(
   parameter int         M    = 8,
   parameter logic [M:0] POLY = '0
) (
   input  logic [M-1:0] i_a,
   input  logic [M-1:0] i_b,
   output logic [M-1:0] o_p
);

   logic [M-1:0] w_acc;
   logic [M-1:0] w_sh;

   always_comb begin
      w_acc = '0;
      w_sh  = i_a;
      for (int i = 0; i < M; i++) begin
         if (i_b[i]) w_acc = w_acc ^ w_sh;
         w_sh = (w_sh << 1) ^ (w_sh[M-1] ? POLY[M-1:0] : '0);
      end
   end

   assign o_p = w_acc;

endmodule

// File: rtl/zl_rs_enc_step.sv
// One LFSR step of the RS parity bank: new[i] = old[i-1] ^ fb*g[i].
// i_old_sh is the old bank already shifted up by one symbol (symbol 0 is zero).
module zl_rs_enc_step
   import zl_rs_pkg::*;
#(
   parameter int              M       = 8,
   parameter int              NK      = 16,
   parameter logic [M*NK-1:0] G_x     = '0,
   parameter logic [M:0]      Gf_poly = '0
) (
   input  logic [M-1:0]    i_fb,
   input  logic [M*NK-1:0] i_old_sh,
   output logic [M*NK-1:0] o_new
);

   localparam logic [GX_MAX_BITS-1:0] G_X_EXT = GX_MAX_BITS'(G_x);

   genvar gi;
   generate
      for (gi = 0; gi < NK; gi++) begin : g_tap
         localparam logic [M-1:0] G_COEF = M'(gx_coef(G_X_EXT, M, gi));
         logic [M-1:0] w_prod;

         zl_gf_mul #(
            .M    (M),
            .POLY (Gf_poly)
         ) u_mul (
            .i_a (i_fb),
            .i_b (G_COEF),
            .o_p (w_prod)
         );

         assign o_new[M*gi +: M] = i_old_sh[M*gi +: M] ^ w_prod;
      end
   endgenerate

endmodule

// File: rtl/zl_rs_encoder_il.sv
// Interleaved, runtime-shortenable systematic RS encoder, one symbol per clock.
// Optional macro ZL_RS_ENC_SHORTEN_EN adds the msg_len port (per-frame length).
module zl_rs_encoder_il
   import zl_rs_pkg::*;
#(
   parameter int                   N       = 255,
   parameter int                   K       = 239,
   parameter int                   M       = 8,
   parameter logic [M*(N-K)-1:0]   G_x     = '0,
   parameter logic [M:0]           Gf_poly = '0,
   parameter int                   DEPTH   = 1
) (
   input  logic         clk,
   input  logic         rst,
`ifdef ZL_RS_ENC_SHORTEN_EN
   input  logic [M-1:0] msg_len,
`endif
   input  logic         data_in_req,
   output logic         data_in_ack,
   input  logic [M-1:0] data_in,
   output logic         data_out_req,
   input  logic         data_out_ack,
   output logic [M-1:0] data_out,
   output logic         data_out_parity,
   output logic         data_out_eof
);

   localparam int NK     = N - K;
   localparam int LANE_W = clog2(DEPTH);
   localparam int ROW_W  = clog2(K);
   localparam int PAR_W  = clog2(DEPTH * NK);
   localparam int P_W    = clog2(NK);
   localparam logic [M-1:0] K_M = M'(K);

   rs_state_t          r_state;
   rs_state_t          w_state_next;
   logic [LANE_W-1:0]  r_lane, w_lane_next;
   logic [ROW_W-1:0]   r_row, w_row_next;
   logic [PAR_W-1:0]   r_par, w_par_next;
   logic [P_W-1:0]     r_pidx, w_pidx_next;
   logic [M*NK-1:0]    r_bank [DEPTH];

   logic [M*NK-1:0]    w_lane_bank;
   logic [M*NK-1:0]    w_old;
   logic [M*NK-1:0]    w_new;
   logic [M-1:0]       w_fb;
   logic [M-1:0]       w_len;
   logic [M-1:0]       w_par_sym;
   logic               w_row0;
   logic               w_lane_last;
   logic               w_row_last;
   logic               w_par_last;
   logic               w_bank_we;

   assign w_row0      = (r_row == '0);
   assign w_lane_last = (r_lane == LANE_W'(DEPTH - 1));
   assign w_par_last  = (r_par == PAR_W'(DEPTH * NK - 1));

`ifdef ZL_RS_ENC_SHORTEN_EN
   logic [M-1:0] r_len;
   logic [M-1:0] w_len_in;
   logic         w_first;

   assign w_len_in = ((msg_len == '0) || (msg_len > K_M)) ? K_M : msg_len;
   assign w_first  = w_row0 && (r_lane == '0);
   // The first symbol of a frame uses the live length, later ones the held copy.
   assign w_len    = w_first ? w_len_in : r_len;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len <= K_M;
      end else if (r_state == ST_DATA && data_in_req && data_out_ack && w_first) begin
         r_len <= w_len_in;
      end
   end
`else
   assign w_len = K_M;
`endif

   assign w_row_last = (M'(r_row) == (w_len - M'(1)));

   // Row 0 reads an implicit all-zero bank, so frames need no clear cycle.
   assign w_lane_bank = r_bank[r_lane];
   assign w_old       = w_row0 ? '0 : w_lane_bank;
   assign w_fb        = data_in ^ w_old[M*NK-1 -: M];
   assign w_par_sym   = w_lane_bank[M*r_pidx +: M];

   zl_rs_enc_step #(
      .M       (M),
      .NK      (NK),
      .G_x     (G_x),
      .Gf_poly (Gf_poly)
   ) u_step (
      .i_fb     (w_fb),
      .i_old_sh (w_old << M),
      .o_new    (w_new)
   );

   always_comb begin
      w_state_next    = r_state;
      w_lane_next     = r_lane;
      w_row_next      = r_row;
      w_par_next      = r_par;
      w_pidx_next     = r_pidx;
      w_bank_we       = 1'b0;
      data_in_ack     = 1'b0;
      data_out_req    = 1'b0;
      data_out        = '0;
      data_out_parity = 1'b0;
      data_out_eof    = 1'b0;
      case (r_state)
         ST_DATA: begin
            data_out_req = data_in_req;
            data_in_ack  = data_out_ack;
            data_out     = data_in;
            if (data_in_req && data_out_ack) begin
               w_bank_we = 1'b1;
               if (w_lane_last) begin
                  w_lane_next = '0;
                  if (w_row_last) begin
                     w_row_next   = '0;
                     w_state_next = ST_PARITY;
                  end else begin
                     w_row_next = r_row + ROW_W'(1);
                  end
               end else begin
                  w_lane_next = r_lane + LANE_W'(1);
               end
            end
         end
         ST_PARITY: begin
            data_out_req    = 1'b1;
            data_out        = w_par_sym;
            data_out_parity = 1'b1;
            data_out_eof    = w_par_last;
            if (data_out_ack) begin
               if (w_par_last) begin
                  w_par_next   = '0;
                  w_lane_next  = '0;
                  w_pidx_next  = P_W'(NK - 1);
                  w_state_next = ST_DATA;
               end else begin
                  w_par_next = r_par + PAR_W'(1);
                  if (w_lane_last) begin
                     w_lane_next = '0;
                     w_pidx_next = r_pidx - P_W'(1);
                  end else begin
                     w_lane_next = r_lane + LANE_W'(1);
                  end
               end
            end
         end
         default: w_state_next = ST_DATA;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_DATA;
         r_lane  <= '0;
         r_row   <= '0;
         r_par   <= '0;
         r_pidx  <= P_W'(NK - 1);
      end else begin
         r_state <= w_state_next;
         r_lane  <= w_lane_next;
         r_row   <= w_row_next;
         r_par   <= w_par_next;
         r_pidx  <= w_pidx_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
      end else if (w_bank_we) begin
         r_bank[r_lane] <= w_new;
      end
   end

endmodule

// File: tb/tb_zl_rs_encoder_il.sv
// Directed bench for zl_rs_encoder_il: RS(15,11) over GF(16), x^4+x+1, interleave depth 3.
module tb_zl_rs_encoder_il;

   localparam int N = 15;
   localparam int K = 11;
   localparam int M = 4;
   localparam int I = 3;
   // g(x) = (x-a)(x-a^2)(x-a^3)(x-a^4) = x^4 + 13x^3 + 12x^2 + 8x + 7
   localparam logic [15:0] GX = 16'hDC87;

   logic         clk = 1'b0;
   logic         rst;
   logic [M-1:0] msg_len;
   logic         data_in_req;
   logic         data_in_ack;
   logic [M-1:0] data_in;
   logic         data_out_req;
   logic         data_out_ack;
   logic [M-1:0] data_out;
   logic         data_out_parity;
   logic         data_out_eof;

   int total = 0;
   int bad   = 0;

   logic [3:0] alog [15];
   int         lg   [16];
   logic [3:0] msg     [I][K];
   logic [3:0] exp_par [I][4];
   logic [3:0] obs_cw  [I][N];

   always #5 clk = ~clk;

   zl_rs_encoder_il #(
      .N       (N),
      .K       (K),
      .M       (M),
      .G_x     (GX),
      .Gf_poly (5'h13),
      .DEPTH   (I)
   ) u_dut (
      .clk             (clk),
      .rst             (rst),
`ifdef ZL_RS_ENC_SHORTEN_EN
      .msg_len         (msg_len),
`endif
      .data_in_req     (data_in_req),
      .data_in_ack     (data_in_ack),
      .data_in         (data_in),
      .data_out_req    (data_out_req),
      .data_out_ack    (data_out_ack),
      .data_out        (data_out),
      .data_out_parity (data_out_parity),
      .data_out_eof    (data_out_eof)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
      if (a == 4'h0 || b == 4'h0) return 4'h0;
      return alog[(lg[a] + lg[b]) % 15];
   endfunction

   function automatic logic [3:0] gdesc(input int j);
      case (j)
         1:       return 4'd13;
         2:       return 4'd12;
         3:       return 4'd8;
         default: return 4'd7;
      endcase
   endfunction

   // Remainder of m(x)*x^4 by long division; c[len] is the x^3 coefficient.
   task automatic compute_expected(input int len);
      logic [3:0] c [N];
      logic [3:0] coef;
      for (int l = 0; l < I; l++) begin
         for (int t = 0; t < N; t++) c[t] = (t < len) ? msg[l][t] : 4'h0;
         for (int i = 0; i < len; i++) begin
            coef = c[i];
            for (int j = 1; j <= 4; j++) c[i+j] = c[i+j] ^ gmul(coef, gdesc(j));
         end
         for (int j = 0; j < 4; j++) exp_par[l][3-j] = c[len+j];
      end
   endtask

   task automatic run_frame(input string name, input int len, input bit stall);
      int n_data, n_total, idx, budget, lane, p;
      int pos [I];
      bit held;
      logic [3:0] s;
      compute_expected(len);
      n_data  = I * len;
      n_total = n_data + I * (N - K);
      idx     = 0;
      budget  = 0;
      held    = 1'b0;
      for (int l = 0; l < I; l++) pos[l] = 0;
      while (idx < n_total && budget < 2000) begin
         @(posedge clk); #1;
         budget++;
         if (!held) begin
            if (idx < n_data) begin
               data_in_req = stall ? ($urandom_range(0, 9) >= 2) : 1'b1;
               data_in     = msg[idx % I][idx / I];
            end else begin
               data_in_req = 1'b0;
               data_in     = 4'($urandom_range(0, 15));
            end
         end
         data_out_ack = stall ? ($urandom_range(0, 9) >= 3) : 1'b1;
`ifdef ZL_RS_ENC_SHORTEN_EN
         if (idx > 0) msg_len = 4'($urandom_range(0, 15));
`endif
         @(negedge clk);
         if (idx < n_data) begin
            chk({name, "_data"},
                {data_out_req, data_in_ack, data_out_parity, data_out_eof, data_out},
                {data_in_req, data_out_ack, 1'b0, 1'b0, data_in});
         end else begin
            lane = (idx - n_data) % I;
            p    = 3 - (idx - n_data) / I;
            chk({name, "_par"},
                {data_out_req, data_in_ack, data_out_parity, data_out_eof, data_out},
                {1'b1, 1'b0, 1'b1, (idx == n_total - 1), exp_par[lane][p]});
         end
         held = data_out_req && !data_out_ack;
         if (data_out_req && data_out_ack) begin
            lane = (idx < n_data) ? (idx % I) : ((idx - n_data) % I);
            obs_cw[lane][pos[lane]] = data_out;
            pos[lane]++;
            idx++;
         end
      end
      chk({name, "_done"}, idx, n_total);
      for (int l = 0; l < I; l++) begin
         for (int r = 1; r <= 4; r++) begin
            s = 4'h0;
            for (int t = 0; t < len + 4; t++) s = gmul(s, alog[r]) ^ obs_cw[l][t];
            chk({name, "_synd"}, s, 4'h0);
         end
      end
   endtask

   task automatic push(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         data_in_req  = 1'b1;
         data_out_ack = 1'b1;
         data_in      = msg[i % I][i / I];
      end
      @(posedge clk); #1;
      data_in_req = 1'b0;
   endtask

   initial begin
      logic [4:0] e;
      e = 5'h1;
      for (int k = 0; k < 15; k++) begin
         alog[k] = e[3:0];
         lg[e[3:0]] = k;
         e = e << 1;
         if (e[4]) e = e ^ 5'h13;
      end
      lg[0] = 0;

      rst = 1'b1;
      data_in_req = 1'b0;
      data_in = 4'h0;
      data_out_ack = 1'b0;
      msg_len = 4'd11;
      #2;
      chk("rst_idle", {data_out_req, data_in_ack, data_out_parity, data_out_eof, data_out}, 8'h00);
      data_in_req = 1'b1;
      data_in = 4'h9;
      data_out_ack = 1'b1;
      #1;
      chk("rst_pass", {data_out_req, data_in_ack, data_out_parity, data_out_eof, data_out},
          {1'b1, 1'b1, 1'b0, 1'b0, 4'h9});
      data_in_req = 1'b0;
      data_out_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int l = 0; l < I; l++) for (int r = 0; r < K; r++) msg[l][r] = 4'h0;
      run_frame("zero", K, 1'b0);

      for (int l = 0; l < I; l++) for (int r = 0; r < K; r++) msg[l][r] = 4'(r + 1);
      run_frame("seq_a", K, 1'b0);
      run_frame("seq_b", K, 1'b0);
      run_frame("seq_c", K, 1'b0);

      for (int r = 0; r < K; r++) begin
         msg[0][r] = 4'(r + 1);
         msg[1][r] = 4'((3 * r + 2) % 16);
         msg[2][r] = 4'(15 - r);
      end
      run_frame("mix", K, 1'b0);
      run_frame("mix_stall", K, 1'b1);

`ifdef ZL_RS_ENC_SHORTEN_EN
      msg_len = 4'd5;
      run_frame("short5", 5, 1'b0);
      msg_len = 4'd0;
      run_frame("len0", K, 1'b0);
      msg_len = 4'd12;
      run_frame("len12", K, 1'b1);
      msg_len = 4'd11;
`endif

      push(6);
      rst = 1'b1;
      #1;
      chk("rst_mid", {data_out_req, data_in_ack, data_out_parity, data_out_eof}, 4'b0100);
      @(negedge clk);
      rst = 1'b0;
      run_frame("after_rst", K, 1'b0);

`ifdef ZL_RS_ENC_SHORTEN_EN
      msg_len = 4'd11;
`endif
      push(I * K);
      @(negedge clk);
      chk("in_par", {data_out_req, data_in_ack, data_out_parity, data_out_eof}, 4'b1010);
      rst = 1'b1;
      #1;
      chk("rst_par", {data_out_req, data_in_ack, data_out_parity, data_out_eof}, 4'b0100);
      @(negedge clk);
      rst = 1'b0;
      for (int l = 0; l < I; l++) for (int r = 0; r < K; r++) msg[l][r] = 4'h0;
      run_frame("zero_again", K, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
